// File: rtl/adder_bist_pkg.sv
// Shared types and width helpers for the adder BIST engine.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    function automatic int unsigned vec_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/adder_bist_cmp.sv
// Golden add of the applied vector and equality against the adder's response.
module adder_bist_cmp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             ok
);

    logic [WIDTH:0] exp_sum;

    assign exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign ok      = ({cout, sum} == exp_sum);

endmodule

// File: rtl/adder_bist.sv
// Exhaustive BIST sequencer for a WIDTH-bit adder: walks {A,B,Cin}, checks each result,
// counts failures and captures the first failing vector.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [WIDTH-1:0]          a_out,
    output logic [WIDTH-1:0]          b_out,
    output logic                      cin_out,
    input  logic [WIDTH-1:0]          sum_in,
    input  logic                      cout_in,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [cnt_w(WIDTH)-1:0]   fail_count,
    output logic                      first_fail_valid,
    output logic [vec_w(WIDTH)-1:0]   first_fail_vec
);

    localparam int unsigned VecW = vec_w(WIDTH);
    localparam int unsigned CntW = cnt_w(WIDTH);
    localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SetW-1:0] SetLast = SetW'(SETTLE - 1);
    localparam logic [VecW-1:0] IdxMax  = '1;

    state_e          state_q;
    logic [VecW-1:0] idx_q;
    logic [SetW-1:0] set_q;
    logic [CntW-1:0] fail_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            ffv_q;
    logic [VecW-1:0] ffvec_q;
    logic            ok;

    assign a_out   = idx_q[VecW-1:WIDTH+1];
    assign b_out   = idx_q[WIDTH:1];
    assign cin_out = idx_q[0];

    adder_bist_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a   (a_out),
        .b   (b_out),
        .cin (cin_out),
        .sum (sum_in),
        .cout(cout_in),
        .ok  (ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            set_q   <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StSettle;
                        idx_q   <= '0;
                        set_q   <= '0;
                        fail_q  <= '0;
                        pass_q  <= 1'b0;
                        ffv_q   <= 1'b0;
                        ffvec_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSettle: begin
                    if (set_q == SetLast) begin
                        set_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        set_q <= set_q + SetW'(1);
                    end
                end
                StCheck: begin
                    if (!ok) begin
                        fail_q <= fail_q + CntW'(1);
                        if (!ffv_q) begin
                            ffv_q   <= 1'b1;
                            ffvec_q <= idx_q;
                        end
                    end
                    if (idx_q == IdxMax) begin
                        // pass must reflect this final check as well
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= ok && (fail_q == '0);
                    end else begin
                        idx_q   <= idx_q + VecW'(1);
                        state_q <= StSettle;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench: two BIST instances (SETTLE=1 and SETTLE=3) driving a behavioural faulty adder.
module tb_adder_bist;

    localparam int N = 512;

    typedef struct {
        int   start_edge;
        int   fc;
        logic ffv;
        int   ffvec;
        logic pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s   [2];
    logic [3:0] a_o       [2];
    logic [3:0] b_o       [2];
    logic       cin_o     [2];
    logic [3:0] sum_i     [2];
    logic       cout_i    [2];
    logic       busy_o    [2];
    logic       done_o    [2];
    logic       pass_o    [2];
    logic [9:0] fc_o      [2];
    logic       ffv_o     [2];
    logic [8:0] ffvec_o   [2];

    int         fault_mode [2];
    int         fault_vec  [2];
    logic [4:0] fault_mask [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    logic run_on    [2];
    int   cur_start [2];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural adder with optional injected faults: 1 = Cout stuck 0,
    // 2 = Sum[0] inverted, 3 = result XOR mask on one chosen vector.
    function automatic logic [4:0] plant(input int mode, input int fv, input logic [4:0] fm,
                                         input int a, input int b, input int c);
        logic [4:0] r;
        r = 5'(a + b + c);
        if (mode == 1) r[4] = 1'b0;
        else if (mode == 2) r[0] = ~r[0];
        else if (mode == 3 && (a * 32 + b * 2 + c) == fv) r = r ^ fm;
        return r;
    endfunction

    assign {cout_i[0], sum_i[0]} = plant(fault_mode[0], fault_vec[0], fault_mask[0],
                                         int'(a_o[0]), int'(b_o[0]), int'(cin_o[0]));
    assign {cout_i[1], sum_i[1]} = plant(fault_mode[1], fault_vec[1], fault_mask[1],
                                         int'(a_o[1]), int'(b_o[1]), int'(cin_o[1]));

    adder_bist #(.WIDTH(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .cin_out(cin_o[0]),
        .sum_in(sum_i[0]), .cout_in(cout_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail_count(fc_o[0]),
        .first_fail_valid(ffv_o[0]), .first_fail_vec(ffvec_o[0])
    );

    adder_bist #(.WIDTH(4), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .cin_out(cin_o[1]),
        .sum_in(sum_i[1]), .cout_in(cout_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail_count(fc_o[1]),
        .first_fail_valid(ffv_o[1]), .first_fail_vec(ffvec_o[1])
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: sweep every vector with plain arithmetic against the plant's response.
    function automatic exp_t model(input int mode, input int fv, input logic [4:0] fm,
                                   input int se);
        exp_t e;
        e.start_edge = se;
        e.fc = 0;
        e.ffv = 1'b0;
        e.ffvec = 0;
        for (int v = 0; v < N; v++) begin
            int a, b, c;
            a = v / 32;
            b = (v / 2) % 16;
            c = v % 2;
            if (int'(plant(mode, fv, fm, a, b, c)) != a + b + c) begin
                if (e.fc == 0) begin
                    e.ffv = 1'b1;
                    e.ffvec = v;
                end
                e.fc++;
            end
        end
        e.pass = (e.fc == 0);
        return e;
    endfunction

    task automatic arm(input int d, input int mode, input int fv, input logic [4:0] fm,
                       input int se);
        exp_t e;
        fault_mode[d] = mode;
        fault_vec[d]  = fv;
        fault_mask[d] = fm;
        e = model(mode, fv, fm, se);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        cur_start[d] = se;
        run_on[d]    = 1'b1;
        start_s[d]   = 1'b1;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        while (!done_o[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_o[d]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: actual=no done required=done within %0d cycles",
                     d, budget);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("%s_a%0d", tag, d), int'(a_o[d]), 0);
        check($sformatf("%s_b%0d", tag, d), int'(b_o[d]), 0);
        check($sformatf("%s_cin%0d", tag, d), int'(cin_o[d]), 0);
        check($sformatf("%s_busy%0d", tag, d), int'(busy_o[d]), 0);
        check($sformatf("%s_done%0d", tag, d), int'(done_o[d]), 0);
        check($sformatf("%s_pass%0d", tag, d), int'(pass_o[d]), 0);
        check($sformatf("%s_fc%0d", tag, d), int'(fc_o[d]), 0);
        check($sformatf("%s_ffv%0d", tag, d), int'(ffv_o[d]), 0);
        check($sformatf("%s_ffvec%0d", tag, d), int'(ffvec_o[d]), 0);
    endtask

    // Monitor: per-cycle vector sequencing while running, scoreboard pop on done.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                int   s;
                int   rel;
                exp_t e;
                s = settle_of(d);
                if (run_on[d]) begin
                    rel = edge_cnt - cur_start[d];
                    if (rel >= 0 && rel < N * (s + 1)) begin
                        check($sformatf("vec_dut%0d_rel%0d", d, rel),
                              int'({a_o[d], b_o[d], cin_o[d]}), rel / (s + 1));
                        check($sformatf("busy_dut%0d_rel%0d", d, rel), int'(busy_o[d]), 1);
                    end
                end
                if (done_o[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        check($sformatf("unexpected_done_dut%0d", d), 1, 0);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check($sformatf("done_edge_dut%0d", d), edge_cnt - e.start_edge,
                              N * (s + 1));
                        check($sformatf("fail_count_dut%0d", d), int'(fc_o[d]), e.fc);
                        check($sformatf("ffv_dut%0d", d), int'(ffv_o[d]), int'(e.ffv));
                        check($sformatf("ffvec_dut%0d", d), int'(ffvec_o[d]), e.ffvec);
                        check($sformatf("pass_dut%0d", d), int'(pass_o[d]), int'(e.pass));
                        check($sformatf("busy_at_done_dut%0d", d), int'(busy_o[d]), 0);
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        start_s    = '{1'b0, 1'b0};
        fault_mode = '{0, 0};
        fault_vec  = '{0, 0};
        fault_mask = '{5'd0, 5'd0};
        run_on     = '{1'b0, 1'b0};
        cur_start  = '{0, 0};

        repeat (3) @(negedge clk);
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free on both instances; DUT0 gets a stray start at edge 50.
        arm(0, 0, 0, 5'd0, edge_cnt + 1);
        arm(1, 0, 0, 5'd0, edge_cnt + 1);
        @(negedge clk);
        start_s = '{1'b0, 1'b0};
        while (edge_cnt < cur_start[0] + 49) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, 1100);
        repeat (4) @(negedge clk);
        check("pass_hold_dut0", int'(pass_o[0]), 1);
        check("fc_hold_dut0", int'(fc_o[0]), 0);
        wait_done(1, 2200);
        @(negedge clk);

        // Cout stuck at 0, then Sum[0] inverted.
        for (int m = 1; m <= 2; m++) begin
            arm(0, m, 0, 5'd0, edge_cnt + 1);
            @(negedge clk);
            start_s[0] = 1'b0;
            wait_done(0, 1100);
            @(negedge clk);
        end

        // Random single-vector faults with random idle gaps.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            arm(0, 3, int'($urandom_range(0, N - 1)), 5'($urandom_range(1, 31)), edge_cnt + 1);
            @(negedge clk);
            start_s[0] = 1'b0;
            wait_done(0, 1100);
            @(negedge clk);
        end
        arm(1, 3, int'($urandom_range(0, N - 1)), 5'($urandom_range(1, 31)), edge_cnt + 1);
        @(negedge clk);
        start_s[1] = 1'b0;
        wait_done(1, 2200);
        @(negedge clk);

        // start held high through DONE: accepted on the first IDLE cycle.
        arm(0, 0, 0, 5'd0, edge_cnt + 1);
        @(negedge clk);
        wait_done(0, 1100);
        arm(0, 1, 0, 5'd0, edge_cnt + 2);
        @(negedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, 1100);
        @(negedge clk);

        // Reset about 100 vectors into a run, then a fresh run.
        arm(0, 2, 0, 5'd0, edge_cnt + 1);
        @(negedge clk);
        start_s[0] = 1'b0;
        e0 = cur_start[0];
        while (edge_cnt < e0 + 200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero(0, "midrun_reset");
        q0.delete();
        run_on = '{1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        arm(0, 3, int'($urandom_range(0, N - 1)), 5'($urandom_range(1, 31)), edge_cnt + 1);
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, 1100);
        @(negedge clk);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Synthesizable built-in self-test engine for the 4-bit adder (`full_add_4`). It drives every `{A, B, Cin}` combination into the adder and samples `{Cout, Sum}` after a programmable settle time. It compares each result against a golden `A+B+Cin` and reports the pass/fail count plus the first failing vector. It sits beside the adder in silicon and performs the stimulus/check role in hardware that the simulation bench performs in software.

## Interface
- `WIDTH`, 4, operand width of the adder under test.
- `SETTLE`, 1, cycles each vector is held before its check cycle; legal range ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a run when sampled high in IDLE.
- `a_out` output WIDTH: operand A to the adder.
- `b_out` output WIDTH: operand B to the adder.
- `cin_out` output 1: carry-in to the adder.
- `sum_in` input WIDTH: adder Sum.
- `cout_in` input 1: adder Cout.
- `busy` output 1: high from the cycle after `start` until `done`.
- `done` output 1: one-cycle pulse at run completion.
- `pass` output 1: high after a run with zero failures; held until the next `start`.
- `fail_count` output 2*WIDTH+2: number of failing vectors in the run.
- `first_fail_valid` output 1: `first_fail_vec` holds a captured vector.
- `first_fail_vec` output 2*WIDTH+1: `{A,B,Cin}` of the first failure.

## Operation
- Vector index `idx` is 2*WIDTH+1 bits wide, laid out `{A,B,Cin}` with A in the MSBs.
  - Vectors are applied in ascending `idx`: A outer, B middle, Cin inner.
  - The sequence is 0 to 2^(2*WIDTH+1)-1, which is 512 vectors for WIDTH=4.
- `a_out`, `b_out` and `cin_out` are driven directly from the registered `idx`, with no combinational path from inputs.
- Golden result is `exp = a_out + b_out + cin_out`, computed at WIDTH+1 bits with no truncation.
  - A vector passes iff `{cout_in, sum_in} == exp`.
- FSM states:
  - IDLE: `start=1` → SETTLE. Same edge clears `idx`, the settle counter, `fail_count`, `pass`, `first_fail_valid` and `first_fail_vec`, and sets `busy`.
  - SETTLE: counts SETTLE cycles, then → CHECK.
  - CHECK: compares the inputs against `exp` and increments `fail_count` on mismatch.
    - On the first mismatch of the run, also captures `idx` into `first_fail_vec` and sets `first_fail_valid`.
    - If `idx` is at its maximum → DONE. Otherwise `idx+1` → SETTLE.
  - DONE: one cycle. `done=1`, `busy` falls, `pass = (fail_count==0)`; then → IDLE.
- `start` is ignored outside IDLE, including in DONE.
- `fail_count` never wraps; its maximum is 2^(2*WIDTH+1).
- Reset at any time, including mid-run:
  - Every output goes to 0 and the state goes to IDLE.
  - The next `start` restarts from `idx=0`.
  - No partial results survive reset.

## Timing
- Reset values: all outputs 0.
- Each vector lasts SETTLE+1 cycles: SETTLE settle cycles plus one CHECK cycle.
- `sum_in` and `cout_in` are sampled only at the rising edge that ends CHECK.
- Counting the edge that samples `start` as edge 0:
  - `done` is high in the cycle after edge N·(SETTLE+1), where N = 2^(2*WIDTH+1).
  - For the defaults this is edge 1024.
- Final `fail_count` and `first_fail_*` are stable when `done` is high and remain stable until the next accepted `start`.
- Back-to-back runs: `start` held high through DONE is accepted on the first IDLE cycle.

## Structure
- Package `adder_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the width functions VEC_W = 2*WIDTH+1 and CNT_W = 2*WIDTH+2.
- One sub-module, `adder_bist_cmp`: combinational golden add and equality, taking `a`, `b`, `cin`, `sum`, `cout` and returning `ok`.
- The FSM, `idx` counter, settle counter and result registers stay in the top module.

## Test plan
- Fault-free `full_add_4`, defaults, `start` pulse → `done` at edge 1024, `pass=1`, `fail_count=0`, `first_fail_valid=0`.
- `cout_in` tied 0 → `fail_count=256`, `first_fail_vec=9'h01F` (A=0, B=15, Cin=1), `pass=0`.
- `sum_in[0]` inverted → `fail_count=512`, `first_fail_vec=0`, `first_fail_valid=1`.
- SETTLE=3, fault-free → each `a_out`/`b_out`/`cin_out` value held 4 cycles, `done` at edge 2048, `pass=1`.
- `start` re-pulsed at edge 50 mid-run → ignored; the run completes normally at edge 1024.
- `rst_n` low at edge 200 (`idx≈100`) → all outputs 0 immediately. A new `start` begins at `idx=0` and completes with the correct counts.
